// File: rtl/demux_1a2_pkt.sv
// demux_1a2_pkt: packet-aware 1-to-2 stream demultiplexer.
// The destination is chosen by s on the first beat of a packet and locked
// until the beat carrying x_last is accepted. Each output has its own
// one-deep register slice and a count of completed packets.
module demux_1a2_pkt #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] x,
    input  logic             x_valid,
    input  logic             x_last,
    input  logic             s,
    output logic             x_ready,
    output logic [WIDTH-1:0] y0,
    output logic [WIDTH-1:0] y1,
    output logic             y0_valid,
    output logic             y1_valid,
    output logic             y0_last,
    output logic             y1_last,
    input  logic             y0_ready,
    input  logic             y1_ready,
    output logic [7:0]       cnt0,
    output logic [7:0]       cnt1
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic             route;
    logic             accept;
    logic [1:0]       out_ready;
    logic [1:0]       valid_arr;
    logic [1:0]       last_arr;
    logic [WIDTH-1:0] data_arr [2];
    logic [7:0]       cnt_arr  [2];

    assign out_ready = {y1_ready, y0_ready};

    // Route follows s only between packets; inside a packet it is pinned.
    always_comb begin
        route = s;
        case (state_q)
            LOCK0:   route = 1'b0;
            LOCK1:   route = 1'b1;
            default: route = s;
        endcase
    end

    // Only the selected output can stall the input.
    assign x_ready = !valid_arr[route] | out_ready[route];
    assign accept  = x_valid & x_ready;

    // Next-state logic: lock on a non-last first beat, unlock on the last beat.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept && !x_last) begin
                    state_d = route ? LOCK1 : LOCK0;
                end
            end
            LOCK0, LOCK1: begin
                if (accept && x_last) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // One identical output slice per destination.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_out
            logic             load;
            logic             drain;
            logic             valid_q;
            logic             valid_d;
            logic             last_q;
            logic             last_d;
            logic [WIDTH-1:0] data_q;
            logic [WIDTH-1:0] data_d;
            logic [7:0]       cnt_q;
            logic [7:0]       cnt_d;

            assign load  = accept & (route == 1'(gi));
            assign drain = valid_q & out_ready[gi];

            // Slice next state: a load wins over a drain so back-to-back beats keep valid high.
            always_comb begin
                data_d  = data_q;
                last_d  = last_q;
                valid_d = valid_q;
                cnt_d   = cnt_q;
                if (drain && last_q) begin
                    cnt_d = cnt_q + 8'd1;
                end
                if (load) begin
                    data_d  = x;
                    last_d  = x_last;
                    valid_d = 1'b1;
                end else if (drain) begin
                    valid_d = 1'b0;
                end
            end

            // Slice registers; reset returns everything to zero.
            always_ff @(posedge clk) begin
                if (rst) begin
                    data_q  <= '0;
                    last_q  <= 1'b0;
                    valid_q <= 1'b0;
                    cnt_q   <= 8'd0;
                end else begin
                    data_q  <= data_d;
                    last_q  <= last_d;
                    valid_q <= valid_d;
                    cnt_q   <= cnt_d;
                end
            end

            assign valid_arr[gi] = valid_q;
            assign last_arr[gi]  = last_q;
            assign data_arr[gi]  = data_q;
            assign cnt_arr[gi]   = cnt_q;
        end
    endgenerate

    assign y0       = data_arr[0];
    assign y1       = data_arr[1];
    assign y0_valid = valid_arr[0];
    assign y1_valid = valid_arr[1];
    assign y0_last  = last_arr[0];
    assign y1_last  = last_arr[1];
    assign cnt0     = cnt_arr[0];
    assign cnt1     = cnt_arr[1];

endmodule
